// File: rtl/cim_pkg.sv
// Shared definitions for the CIM tile and the fc-layer controller: FSM states and
// derived-width helpers so both ends of the interface compute identical widths.
package cim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COMMIT  = 2'd2
  } cim_state_t;

  function automatic int calc_obuf_data_size(input int data_size, input int xbar_size);
    return 2 * data_size + $clog2(xbar_size);
  endfunction

  function automatic int calc_num_channels(input int obuf_bus_width, input int obuf_data_size);
    return obuf_bus_width / obuf_data_size;
  endfunction

  function automatic int calc_num_addr_obuf(input int elements_per_tile, input int num_channels);
    return (elements_per_tile + num_channels - 1) / num_channels;
  endfunction

endpackage

// File: rtl/cim_tile_wmem.sv
// Weight RAM for the CIM tile: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module cim_tile_wmem #(
  parameter int XBAR_SIZE = 64,
  parameter int WORD_W    = 64,
  localparam int IDX_W    = $clog2(XBAR_SIZE)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_row,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [XBAR_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[wr_row] <= wr_data;
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/cim_tile_model.sv
// Behavioural CIM crossbar tile: bus-loaded input vector, row-serial MVM, addressed output buffer.
// Optional macro CIM_TILE_SIGNED_EN selects two's-complement x/w/acc (widths unchanged).
module cim_tile_model
  import cim_pkg::*;
#(
  parameter int XBAR_SIZE      = 64,
  parameter int DATA_SIZE      = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int OBUF_BUS_WIDTH = 46,
  localparam int OBUF_DATA_SIZE    = calc_obuf_data_size(DATA_SIZE, XBAR_SIZE),
  localparam int NUM_CHANNELS      = calc_num_channels(OBUF_BUS_WIDTH, OBUF_DATA_SIZE),
  localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE,
  localparam int ELEMS_PER_WORD    = BUS_WIDTH / DATA_SIZE,
  localparam int NUM_ADDR          = XBAR_SIZE / ELEMS_PER_WORD,
  localparam int NUM_ADDR_OBUF     = calc_num_addr_obuf(ELEMENTS_PER_TILE, NUM_CHANNELS),
  localparam int ADDR_W            = $clog2(NUM_ADDR),
  localparam int OBUF_ADDR_W       = $clog2(NUM_ADDR_OBUF),
  localparam int ROW_W             = $clog2(XBAR_SIZE),
  localparam int WROW_W            = ELEMENTS_PER_TILE * DATA_SIZE
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         i_we,
  input  logic [ADDR_W-1:0]                            i_addr,
  input  logic [BUS_WIDTH-1:0]                         i_data,
  output logic                                         o_ready,
  input  logic [OBUF_ADDR_W-1:0]                       i_obuf_addr,
  output logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0]  o_data,
  input  logic                                         i_wgt_we,
  input  logic [ROW_W-1:0]                             i_wgt_row,
  input  logic [WROW_W-1:0]                            i_wgt_data,
  output logic                                         o_err
);

  cim_state_t                state;
  logic [ROW_W-1:0]          row;
  logic [DATA_SIZE-1:0]      x_reg [XBAR_SIZE];
  logic [OBUF_DATA_SIZE-1:0] acc   [ELEMENTS_PER_TILE];
  logic [OBUF_DATA_SIZE-1:0] obuf  [ELEMENTS_PER_TILE];
  logic [WROW_W-1:0]         wrow;
  logic                      idle;
  logic                      wr_last;

  assign idle    = (state == IDLE);
  assign wr_last = idle && i_we && (i_addr == ADDR_W'(NUM_ADDR - 1));

  cim_tile_wmem #(
    .XBAR_SIZE (XBAR_SIZE),
    .WORD_W    (WROW_W)
  ) u_wmem (
    .clk     (clk),
    .we      (i_wgt_we && idle),
    .wr_row  (i_wgt_row),
    .wr_data (i_wgt_data),
    .rd_row  (row),
    .rd_data (wrow)
  );

  function automatic logic [OBUF_DATA_SIZE-1:0] mac(
    input logic [OBUF_DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0]      x,
    input logic [DATA_SIZE-1:0]      w
  );
`ifdef CIM_TILE_SIGNED_EN
    logic signed [2*DATA_SIZE-1:0] ps;
    ps = $signed({{DATA_SIZE{x[DATA_SIZE-1]}}, x}) * $signed({{DATA_SIZE{w[DATA_SIZE-1]}}, w});
    return a + {{(OBUF_DATA_SIZE-2*DATA_SIZE){ps[2*DATA_SIZE-1]}}, ps};
`else
    logic [2*DATA_SIZE-1:0] pu;
    pu = {{DATA_SIZE{1'b0}}, x} * {{DATA_SIZE{1'b0}}, w};
    return a + {{(OBUF_DATA_SIZE-2*DATA_SIZE){1'b0}}, pu};
`endif
  endfunction

  function automatic logic [OBUF_DATA_SIZE-1:0] obuf_word(
    input logic [OBUF_ADDR_W-1:0] a,
    input int                     c
  );
    int idx;
    idx = int'(a) * NUM_CHANNELS + c;
    if (int'(a) >= NUM_ADDR_OBUF || idx >= ELEMENTS_PER_TILE) return '0;
    return obuf[idx];
  endfunction

  // Control: state, row counter, ready and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      o_ready <= 1'b1;
      o_err   <= 1'b0;
    end else begin
      if (!idle && (i_we || i_wgt_we)) o_err <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_last) begin
            state   <= COMPUTE;
            row     <= '0;
            o_ready <= 1'b0;
          end
        end
        COMPUTE: begin
          row <= row + 1'b1;
          if (row == ROW_W'(XBAR_SIZE - 1)) state <= COMMIT;
        end
        COMMIT: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: input vector, accumulators, committed output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < XBAR_SIZE; r++) x_reg[r] <= '0;
      for (int j = 0; j < ELEMENTS_PER_TILE; j++) begin
        acc[j]  <= '0;
        obuf[j] <= '0;
      end
    end else begin
      if (idle && i_we) begin
        for (int k = 0; k < ELEMS_PER_WORD; k++)
          x_reg[int'(i_addr) * ELEMS_PER_WORD + k] <= i_data[k*DATA_SIZE +: DATA_SIZE];
      end
      for (int j = 0; j < ELEMENTS_PER_TILE; j++) begin
        if (wr_last)
          acc[j] <= '0;
        else if (state == COMPUTE)
          acc[j] <= mac(acc[j], x_reg[row], wrow[j*DATA_SIZE +: DATA_SIZE]);
        if (state == COMMIT) obuf[j] <= acc[j];
      end
    end
  end

  // Read port: one-cycle registered read, live in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) o_data[c] <= obuf_word(i_obuf_addr, c);
    end
  end

endmodule
